// File: rtl/fsb8_pkg.sv
// Shared FSB8 definitions: target state encoding, address width, transfer types, address-byte slices.
package fsb8_pkg;

    localparam int FSB8_AW = 24;

    localparam logic TYP_SINGLE = 1'b0;
    localparam logic TYP_BLOCK  = 1'b1;

    localparam int AHI_MSB  = 23;
    localparam int AHI_LSB  = 16;
    localparam int AMID_MSB = 15;
    localparam int AMID_LSB = 8;
    localparam int ALO_MSB  = 7;
    localparam int ALO_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ACCESS,
        ST_RESP,
        ST_HOLD,
        ST_IGNORE
    } tgt_state_e;

endpackage

// File: rtl/fsb8_tgt_timeout.sv
// Local-ack timeout: down-counter reloaded outside ACCESS, expires at terminal count zero.
module fsb8_tgt_timeout #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/fsb8_target.sv
// FSB8 device-side responder bridging claimed bus beats to a req/ack local port.
// Optional local-ack timeout is built only when FSB8_TGT_TIMEOUT_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus idle, waiting for first address cycle (A[23:16])
// ADDR      | second address cycle: A[15:0], direction, type, space
// DATA      | data cycle, write data captured from AD8
// ACCESS    | local request outstanding until loc_ack (or timeout)
// RESP      | one-cycle rdy_n, read data driven on AD8
// HOLD      | beat done, waiting for cs_n to rise
// IGNORE    | not our transaction or malformed, waiting for cs_n to rise
module fsb8_target
    import fsb8_pkg::*;
#(
    parameter logic [7:0] BASE_HI     = 8'h40,
    parameter bit         CMD_RESPOND = 1'b0,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ale_n,
    input  logic               cs_n,
    input  logic               cmd_n,
    input  logic               typ,
    input  logic               wr_n,
    input  logic [7:0]         ad_in,
    input  logic [7:0]         aah8,
    output logic [7:0]         ad_out,
    output logic               ad_oe,
    output logic               rdy_n_o,
    output logic               rdy_oe,
    output logic               irq_oe,
    output logic [FSB8_AW-1:0] loc_addr,
    output logic               loc_we,
    output logic               loc_cmd,
    output logic [7:0]         loc_wdata,
    output logic               loc_req,
    input  logic               loc_ack,
    input  logic [7:0]         loc_rdata,
    input  logic               loc_irq,
    output logic               bus_err
);
    tgt_state_e  r_state, w_next;
    logic [7:0]  r_ahi;
    logic [15:0] r_addr16;
    logic        r_wr, r_typ, r_cmd, r_abort, r_bus_err, r_irq;
    logic [7:0]  r_wdata, r_rdata;
    logic        w_hit, w_err, w_expire;

`ifdef FSB8_TGT_TIMEOUT_EN
    fsb8_tgt_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_load   (r_state != ST_ACCESS),
        .i_en     (r_state == ST_ACCESS),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_expire         = 1'b0;
`endif

    assign w_hit = (r_ahi == BASE_HI) && (cmd_n || CMD_RESPOND);

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE:   if (!cs_n && !ale_n) w_next = ST_ADDR;
            ST_ADDR: begin
                if (cs_n) begin
                    w_next = ST_IDLE;
                end else if (ale_n) begin
                    w_next = ST_IGNORE;
                    w_err  = 1'b1;
                end else begin
                    w_next = w_hit ? ST_DATA : ST_IGNORE;
                end
            end
            ST_DATA:   w_next = cs_n ? ST_IDLE : ST_ACCESS;
            // An ack coinciding with expiry is a normal completion.
            ST_ACCESS: begin
                if (loc_ack || w_expire) begin
                    w_next = (cs_n || r_abort) ? ST_IDLE : ST_RESP;
                    w_err  = !loc_ack;
                end
            end
            ST_RESP: begin
                if (cs_n)                     w_next = ST_IDLE;
                else if (r_typ == TYP_BLOCK)  w_next = ST_DATA;
                else                          w_next = ST_HOLD;
            end
            ST_HOLD, ST_IGNORE: if (cs_n) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ahi     <= '0;
            r_addr16  <= '0;
            r_wr      <= 1'b0;
            r_typ     <= TYP_SINGLE;
            r_cmd     <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_abort   <= 1'b0;
            r_bus_err <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_bus_err <= w_err;
            r_irq     <= loc_irq;
            case (r_state)
                ST_IDLE: if (!cs_n && !ale_n) r_ahi <= ad_in;
                ST_ADDR: begin
                    if (!cs_n && !ale_n) begin
                        r_addr16 <= {aah8, ad_in};
                        r_wr     <= !wr_n;
                        r_typ    <= typ;
                        r_cmd    <= !cmd_n;
                    end
                end
                ST_DATA: begin
                    r_abort <= 1'b0;
                    if (r_wr) r_wdata <= ad_in;
                end
                // Abort seen mid-handshake is remembered so the ack still completes locally.
                ST_ACCESS: begin
                    if (cs_n)          r_abort <= 1'b1;
                    if (loc_ack)       r_rdata <= loc_rdata;
                    else if (w_expire) r_rdata <= 8'hFF;
                end
                ST_RESP: if ((r_typ == TYP_BLOCK) && !cs_n) r_addr16 <= r_addr16 + 16'd1;
                default: ;
            endcase
        end
    end

    assign loc_req   = (r_state == ST_ACCESS);
    assign rdy_oe    = (r_state == ST_RESP);
    assign rdy_n_o   = 1'b0;
    assign ad_oe     = rdy_oe && !r_wr;
    assign ad_out    = ad_oe ? r_rdata : 8'h00;
    assign loc_addr  = {r_ahi, r_addr16};
    assign loc_we    = r_wr;
    assign loc_cmd   = r_cmd;
    assign loc_wdata = r_wdata;
    assign bus_err   = r_bus_err;
    assign irq_oe    = r_irq;

endmodule

// File: tb/tb_fsb8_target.sv
// Bench for fsb8_target: directed transaction table plus random transactions checked against a memory-level model.
`timescale 1ns/1ps
module tb_fsb8_target;
    import fsb8_pkg::*;

    localparam logic [7:0] BASE   = 8'h40;
    localparam int         TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ale_n, cs_n, cmd_n, typ, wr_n;
    logic [7:0]  ad_in, aah8;
    logic [7:0]  ad_out;
    logic        ad_oe, rdy_n_o, rdy_oe, irq_oe;
    logic [23:0] loc_addr;
    logic        loc_we, loc_cmd, loc_req, loc_ack, loc_irq, bus_err;
    logic [7:0]  loc_wdata, loc_rdata;

    fsb8_target #(.BASE_HI(BASE), .CMD_RESPOND(1'b0), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .ale_n(ale_n), .cs_n(cs_n), .cmd_n(cmd_n), .typ(typ),
        .wr_n(wr_n), .ad_in(ad_in), .aah8(aah8), .ad_out(ad_out), .ad_oe(ad_oe),
        .rdy_n_o(rdy_n_o), .rdy_oe(rdy_oe), .irq_oe(irq_oe), .loc_addr(loc_addr),
        .loc_we(loc_we), .loc_cmd(loc_cmd), .loc_wdata(loc_wdata), .loc_req(loc_req),
        .loc_ack(loc_ack), .loc_rdata(loc_rdata), .loc_irq(loc_irq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Local device: byte memory with programmable ack latency.
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    int ack_dly   = 0;
    bit ack_never = 1'b0;
    int rsp_wait  = 0;

    initial begin
        loc_ack = 1'b0;
        loc_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (loc_ack) begin
                loc_ack = 1'b0;
            end else if (loc_req && !rst && !ack_never) begin
                if (rsp_wait >= ack_dly) begin
                    loc_ack   = 1'b1;
                    loc_rdata = mem[loc_addr[15:0]];
                    if (loc_we) mem[loc_addr[15:0]] = loc_wdata;
                    rsp_wait  = 0;
                end else begin
                    rsp_wait++;
                end
            end else begin
                rsp_wait = 0;
            end
        end
    end

    // Observations gathered per transaction.
    typedef struct packed {
        logic [23:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        cmd;
    } req_t;

    req_t       q_req[$];
    logic [7:0] q_rd[$];
    int n_rdy, n_berr, n_bad, n_reqcyc;
    bit cur_wr = 1'b0;
    bit mon_prev_req = 1'b0;
    bit mon_prev_cs  = 1'b1;
    req_t mon_prev;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (loc_req) begin
                    n_reqcyc++;
                    if (!mon_prev_req) q_req.push_back({loc_addr, loc_we, loc_wdata, loc_cmd});
                    else if (mon_prev != {loc_addr, loc_we, loc_wdata, loc_cmd}) n_bad++;
                end
                if (rdy_oe) begin
                    n_rdy++;
                    if (rdy_n_o) n_bad++;
                end
                if (ad_oe) begin
                    if (!rdy_oe || cur_wr || mon_prev_cs) n_bad++;
                    q_rd.push_back(ad_out);
                end
                if (bus_err) n_berr++;
            end
            mon_prev_req = loc_req;
            mon_prev     = {loc_addr, loc_we, loc_wdata, loc_cmd};
            mon_prev_cs  = cs_n;
        end
    end

    typedef struct {
        logic [23:0] addr;
        bit   wr, blk, cmd, bad_ale, abort, never;
        int   beats, dly, hold;
        logic [7:0] wd0;
        int   e_reqs, e_rdy, e_err;
    } txn_t;

    function automatic txn_t mk(input logic [23:0] addr, input bit wr, input bit blk, input int beats,
                                input bit cmd, input bit bad_ale, input bit abort, input bit never,
                                input int dly, input int hold, input logic [7:0] wd0,
                                input int e_reqs, input int e_rdy, input int e_err);
        txn_t t;
        t.addr = addr; t.wr = wr; t.blk = blk; t.beats = beats; t.cmd = cmd;
        t.bad_ale = bad_ale; t.abort = abort; t.never = never; t.dly = dly; t.hold = hold;
        t.wd0 = wd0; t.e_reqs = e_reqs; t.e_rdy = e_rdy; t.e_err = e_err;
        return t;
    endfunction

    function automatic bit exp_hit(input txn_t t);
        return !t.bad_ale && (t.addr[23:16] == BASE) && !t.cmd;
    endfunction

    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        bit hit = exp_hit(t);
        r.e_err  = t.bad_ale ? 1 : ((hit && t.never) ? 1 : 0);
        r.e_reqs = !hit ? 0 : (t.abort ? 1 : t.beats);
        r.e_rdy  = (!hit || t.abort) ? 0 : t.beats;
        return r;
    endfunction

    function automatic logic [7:0] wdata_of(input txn_t t, input int b);
        return t.wd0 + 8'(17 * b);
    endfunction

    task automatic run_txn(input txn_t t, input string tag);
        bit ok;
        bit hit = exp_hit(t);
        logic [15:0] ai;
        q_req.delete(); q_rd.delete();
        n_rdy = 0; n_berr = 0; n_bad = 0; n_reqcyc = 0;
        cur_wr = t.wr; ack_dly = t.dly; ack_never = t.never;
        @(negedge clk);
        cs_n = 1'b0; ale_n = 1'b0; ad_in = t.addr[23:16]; aah8 = 8'h00;
        cmd_n = !t.cmd; wr_n = !t.wr; typ = t.blk;
        @(negedge clk);
        ad_in = t.addr[7:0]; aah8 = t.addr[15:8]; ale_n = t.bad_ale;
        @(negedge clk);
        ale_n = 1'b1; ad_in = wdata_of(t, 0);
        if (hit && t.abort) begin
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                if (loc_req) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            check({tag, " abort req seen"}, 32'(ok), 32'd1);
            cs_n = 1'b1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (!loc_req) break;
            end
            check({tag, " abort to idle"}, 32'(dut.r_state), 32'(ST_IDLE));
        end else if (hit) begin
            for (int b = 0; b < t.beats; b++) begin
                ok = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (rdy_oe) begin ok = 1'b1; break; end
                end
                if (!ok) begin
                    check({tag, " rdy wait"}, 32'd0, 32'd1);
                    break;
                end
                if (b < t.beats - 1) ad_in = wdata_of(t, b + 1);
            end
            if (t.blk || t.hold == 0) begin
                cs_n = 1'b1;
            end else begin
                @(negedge clk);
                check({tag, " hold state"}, 32'(dut.r_state), 32'(ST_HOLD));
                repeat (t.hold - 1) @(negedge clk);
                cs_n = 1'b1;
            end
        end else begin
            @(negedge clk);
            check({tag, " ignore state"}, 32'(dut.r_state), 32'(ST_IGNORE));
            repeat (t.hold) @(negedge clk);
            cs_n = 1'b1;
        end
        ale_n = 1'b1; cmd_n = 1'b1; wr_n = 1'b1; typ = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, " idle state"}, 32'(dut.r_state), 32'(ST_IDLE));
        check({tag, " idle drivers"}, 32'({loc_req, rdy_oe, ad_oe}), 32'd0);
        check({tag, " req count"}, 32'(q_req.size()), 32'(t.e_reqs));
        check({tag, " rdy count"}, 32'(n_rdy), 32'(t.e_rdy));
        check({tag, " bus_err count"}, 32'(n_berr), 32'(t.e_err));
        check({tag, " protocol"}, 32'(n_bad), 32'd0);
        for (int i = 0; i < q_req.size() && i < t.e_reqs; i++) begin
            ai = t.addr[15:0] + 16'(i);
            check({tag, " req addr"}, 32'(q_req[i].addr), 32'({t.addr[23:16], ai}));
            check({tag, " req we"}, 32'(q_req[i].we), 32'(t.wr));
            check({tag, " req cmd"}, 32'(q_req[i].cmd), 32'(t.cmd));
            if (t.wr) check({tag, " req wdata"}, 32'(q_req[i].wdata), 32'(wdata_of(t, i)));
        end
        check({tag, " read beats"}, 32'(q_rd.size()), t.wr ? 32'd0 : 32'(t.e_rdy));
        for (int i = 0; i < q_rd.size() && i < t.e_rdy && !t.wr; i++) begin
            ai = t.addr[15:0] + 16'(i);
            check({tag, " read data"}, 32'(q_rd[i]), t.never ? 32'hFF : 32'(ref_mem[ai]));
        end
        if (t.wr && hit && !t.never) begin
            for (int i = 0; i < t.e_reqs; i++) begin
                ai = t.addr[15:0] + 16'(i);
                ref_mem[ai] = wdata_of(t, i);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    txn_t dir[$];
    txn_t rt;
    logic prev_irq;
    int   r;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h96;
            ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h96;
        end
        mem[16'h0010] = 8'hC3;
        ref_mem[16'h0010] = 8'hC3;

        rst = 1'b1; ale_n = 1'b1; cs_n = 1'b1; cmd_n = 1'b1; typ = 1'b0; wr_n = 1'b1;
        ad_in = 8'h00; aah8 = 8'h00; loc_irq = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({ad_out, ad_oe, rdy_n_o, rdy_oe, irq_oe, loc_we, loc_cmd,
                                     loc_wdata, loc_req, bus_err}), 32'd0);
        check("reset loc_addr", 32'(loc_addr), 32'd0);
        check("reset state", 32'(dut.r_state), 32'(ST_IDLE));
        loc_irq = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        //               addr        wr blk bt cmd bad abt nev dly hold wd0     reqs rdy err
        dir.push_back(mk(24'h401234, 1, 0, 1, 0,  0,  0,  0,  2,  1,  8'h5A,  1,   1,  0));
        dir.push_back(mk(24'h400010, 0, 0, 1, 0,  0,  0,  0,  1,  2,  8'h00,  1,   1,  0));
        dir.push_back(mk(24'h40FFFE, 0, 1, 3, 0,  0,  0,  0,  0,  0,  8'h00,  3,   3,  0));
        dir.push_back(mk(24'h410000, 0, 0, 1, 0,  0,  0,  0,  0,  2,  8'h00,  0,   0,  0));
        dir.push_back(mk(24'h400100, 0, 0, 1, 1,  0,  0,  0,  0,  1,  8'h00,  0,   0,  0));
        dir.push_back(mk(24'h400000, 0, 0, 1, 0,  1,  0,  0,  0,  1,  8'h00,  0,   0,  1));
        dir.push_back(mk(24'h400020, 0, 0, 1, 0,  0,  1,  0,  3,  0,  8'h00,  1,   0,  0));
        dir.push_back(mk(24'h40ABCD, 1, 1, 2, 0,  0,  0,  0,  1,  0,  8'h11,  2,   2,  0));
        dir.push_back(mk(24'h40ABCE, 0, 0, 1, 0,  0,  0,  0,  0,  0,  8'h00,  1,   1,  0));
        for (int i = 0; i < dir.size(); i++) begin
            run_txn(dir[i], $sformatf("dir%0d", i));
            if (i == 1 && q_rd.size() > 0) check("single read C3", 32'(q_rd[0]), 32'hC3);
            if (i == 2 && q_req.size() > 2) check("block wrap addr", 32'(q_req[2].addr), 32'h400000);
            if (i == 8 && q_rd.size() > 0) check("readback block write", 32'(q_rd[0]), 32'h22);
        end

`ifdef FSB8_TGT_TIMEOUT_EN
        run_txn(mk(24'h400030, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 1, 1, 1), "timeout");
        check("timeout req cycles", 32'(n_reqcyc), 32'(TO_CYC));
        ack_never = 1'b0;
`endif

        // Reset while a write is waiting for its ack.
        ack_dly = 20; cur_wr = 1'b1;
        @(negedge clk);
        cs_n = 1'b0; ale_n = 1'b0; ad_in = 8'h40; cmd_n = 1'b1; wr_n = 1'b0; typ = 1'b0;
        @(negedge clk);
        ad_in = 8'h78; aah8 = 8'h56;
        @(negedge clk);
        ale_n = 1'b1; ad_in = 8'hE7;
        @(negedge clk);
        check("pre-reset req", 32'({loc_req, loc_we, loc_wdata}), 32'({1'b1, 1'b1, 8'hE7}));
        check("pre-reset addr", 32'(loc_addr), 32'h405678);
        rst = 1'b1;
        @(negedge clk);
        check("mid-access reset outputs", 32'({ad_out, ad_oe, rdy_oe, irq_oe, loc_we, loc_cmd,
                                               loc_wdata, loc_req, bus_err}), 32'd0);
        check("mid-access reset addr", 32'(loc_addr), 32'd0);
        rst = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check("post-reset state", 32'(dut.r_state), 32'(ST_IDLE));

        // Interrupt reflection.
        prev_irq = loc_irq;
        for (int i = 0; i < 10; i++) begin
            loc_irq = 1'($urandom_range(0, 1));
            prev_irq = loc_irq;
            @(negedge clk);
            check("irq_oe follows loc_irq", 32'(irq_oe), 32'(prev_irq));
        end
        loc_irq = 1'b0;

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 7);
            rt.addr[23:16] = (r < 6) ? BASE : ((r == 6) ? 8'h41 : 8'($urandom));
            rt.addr[15:0]  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rt.addr[15:0] = 16'hFFFC + 16'($urandom_range(0, 3));
            rt.wr      = 1'($urandom_range(0, 1));
            rt.blk     = 1'($urandom_range(0, 1));
            rt.beats   = rt.blk ? $urandom_range(1, 4) : 1;
            rt.cmd     = ($urandom_range(0, 7) == 0);
            rt.bad_ale = ($urandom_range(0, 9) == 0);
            rt.abort   = !rt.blk && ($urandom_range(0, 7) == 0);
            rt.never   = 1'b0;
            rt.dly     = $urandom_range(0, 4);
            rt.hold    = rt.blk ? 0 : $urandom_range(0, 3);
            rt.wd0     = 8'($urandom);
            rt = model(rt);
            run_txn(rt, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsb8_target.md
Name: fsb8_target

Overview:
- Device-side responder for the FSB8 external bus: the other end of the FSB8 bus controller in the LS1u SoC.
- Decodes FSB8 address phases, claims transactions whose A[23:16] matches a programmed window, and bridges each data beat to a simple req/ack local port (register file, SRAM, peripheral).
- Drives rdy_n and the read data on AD8; reflects a local interrupt onto irq_n.
- Runs entirely on the FSB8 bus clock (busclk).

Parameters:
- BASE_HI, 8'h40, A[23:16] value this target claims.
- CMD_RESPOND, 0, 1 = also claim cmd_n-low (command space) cycles; 0 = ignore them.
- TIMEOUT_CYC, 64, local-ack timeout in clk cycles (used only with FSB8_TGT_TIMEOUT_EN).

Ports:
- clk  in  1  FSB8 bus clock (busclk).
- rst  in  1  synchronous, active-high reset.
- ale_n  in  1  address latch enable.
- cs_n  in  1  transaction select; high = bus idle or abort.
- cmd_n  in  1  low = command space.
- typ  in  1  0 = SINGLE, 1 = BLOCK.
- wr_n  in  1  low = write.
- ad_in  in  8  AD8 input.
- aah8  in  8  A[15:8].
- ad_out  out  8  AD8 read data.
- ad_oe  out  1  AD8 output enable.
- rdy_n_o  out  1  ready value; always 0 when driven.
- rdy_oe  out  1  rdy_n driver enable (open-drain style).
- irq_oe  out  1  pulls irq_n low.
- loc_addr  out  24  local address.
- loc_we  out  1  local write.
- loc_cmd  out  1  command-space access.
- loc_wdata  out  8  local write data.
- loc_req  out  1  local request.
- loc_ack  in  1  local acknowledge.
- loc_rdata  in  8  local read data.
- loc_irq  in  1  local interrupt, active high.
- bus_err  out  1  one-cycle pulse on protocol error or timeout.

Behaviour:
- Reset values: all outputs 0; loc_addr = 0; ad_out = 0; state = IDLE.
- FSB8 address phase is two cycles, with ale_n low and cs_n low in both:
  - Cycle A0: AD8 = A[23:16].
  - Cycle A1: AD8 = A[7:0], AAH8 = A[15:8].
- States: IDLE, ADDR, DATA, ACCESS, RESP, HOLD, IGNORE.
- IDLE: on cs_n=0 and ale_n=0, latch ahi = ad_in and go to ADDR.
- ADDR:
  - If ale_n=1: pulse bus_err, go to IGNORE.
  - Otherwise latch A[7:0] = ad_in, A[15:8] = aah8, plus wr, typ and cmd.
  - Hit = (ahi == BASE_HI) and (cmd_n or CMD_RESPOND). Hit goes to DATA; miss goes to IGNORE.
- DATA (ale_n high): for a write, latch loc_wdata = ad_in. Go to ACCESS.
- ACCESS:
  - loc_req = 1, with loc_addr/loc_we/loc_cmd/loc_wdata stable until loc_ack is sampled 1.
  - On ack: latch loc_rdata and drop loc_req in the next cycle. Never two reqs back-to-back without an intervening low cycle.
- RESP (exactly one cycle):
  - rdy_oe = 1, rdy_n_o = 0.
  - For a read: ad_oe = 1, ad_out = latched data.
  - Then: if typ = BLOCK and cs_n = 0, A[15:0] += 1 (wraps FFFF→0000; A[23:16] fixed) and go to DATA. Otherwise go to HOLD.
- HOLD / IGNORE: all bus drivers off; return to IDLE when cs_n = 1.
- Abort (cs_n = 1 sampled):
  - In ADDR or DATA: go to IDLE next cycle.
  - In ACCESS: finish the local handshake first, then go to IDLE with no RESP.
  - In RESP: the beat completes; then IDLE.
- ad_oe is never asserted in a write transaction, nor in the cycle after cs_n rises.
- Interrupt: irq_oe is a one-cycle registered copy of loc_irq; it is independent of the state machine.
- All outputs are registered or decoded directly from registered state (Moore).

Optional Feature:
- FSB8_TGT_TIMEOUT_EN defined:
  - A counter runs in ACCESS. On TIMEOUT_CYC cycles without loc_ack: drop loc_req, pulse bus_err, and go to RESP with read data 8'hFF (a write is discarded).
  - A loc_ack arriving in the same cycle as expiry wins.
- Undefined: ACCESS waits for loc_ack indefinitely; no counter logic is generated.

Decomposition:
- Package fsb8_pkg:
  - Target state encoding.
  - FSB8_AW = 24.
  - TYP_SINGLE = 0, TYP_BLOCK = 1.
  - Address-byte slice constants.
- Optional sub-module fsb8_tgt_timeout (load/clear/expire counter), instantiated only under FSB8_TGT_TIMEOUT_EN.

Test Plan:
- Single write: A = 40_1234, data 5A, loc_ack after 2 cycles → loc_addr = 401234, loc_we = 1, loc_wdata = 5A; rdy_oe for 1 cycle; ad_oe never high.
- Single read: A = 40_0010, loc_rdata = C3 → RESP cycle has ad_oe = 1, ad_out = C3, rdy_n_o = 0; then HOLD until cs_n rises.
- Block read of 3 beats from 40_FFFE → loc_addr sequence 40FFFE, 40FFFF, 400000; three RESP pulses.
- Miss: A = 41_0000 → no loc_req, rdy_oe and ad_oe stay 0; back to IDLE once cs_n = 1. Also: ale_n high in ADDR → bus_err pulse, target goes to IGNORE.
- Abort: cs_n rises while in ACCESS → loc_req held until loc_ack, no RESP, state is IDLE the cycle after. Reset asserted mid-ACCESS → all outputs 0 next cycle.
- FSB8_TGT_TIMEOUT_EN with TIMEOUT_CYC = 8 and loc_ack held 0 → bus_err pulse after 8 cycles; read returns FF with rdy.
